// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 register-file responder.
// The command byte carries the register address in [7:3] and the write flag in bit 1.
package spi_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } state_t;

    localparam int ADDR_W       = 5;
    localparam int CMD_ADDR_MSB = 7;
    localparam int CMD_ADDR_LSB = 3;
    localparam int CMD_DIR_BIT  = 1;

    localparam logic [ADDR_W-1:0] ADDR_IEN = 5'h1E;
    localparam logic [ADDR_W-1:0] ADDR_IRQ = 5'h1F;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// rise/fall pulses that stay aligned with the registered level output.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Everything resets low, so a pin held low across reset never looks like a fresh fall.
    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = async_in;
        prev_d    = sync_q[STAGES-1];
        rise_d    = sync_q[STAGES-1] & ~prev_q;
        fall_d    = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level_out = prev_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target with a 32x8 register file, MAX3421E-style command framing.
// Optional interrupt registers (IEN at 0x1E, W1C IRQ at 0x1F) with SPI_RESPONDER_IRQ_EN.
module spi_responder
    import spi_responder_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sclk_in,
    input  logic              n_ss_in,
    input  logic              mosi_in,
    output logic              miso_out,
    input  logic [7:0]        status_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    output logic [7:0]        rd_data_out,
    output logic              wr_valid_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out
`ifdef SPI_RESPONDER_IRQ_EN
    ,
    input  logic [7:0]        irq_in,
    output logic              n_int_out
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic sclk_rise, sclk_fall, sclk_level;
    logic ss_rise, ss_fall, ss_level;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_in_q, shift_in_d;
    logic [7:0]        shift_out_q, shift_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              load_pending_q, load_pending_d;
    logic              miso_q, miso_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        regs_d [NUM_REGS];

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_inc;
    logic              ss_edge, byte_done, cmd_done, wr_fire, rd_load;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .async_in  (sclk_in),
        .level_out (sclk_level),
        .rise_out  (sclk_rise),
        .fall_out  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .async_in  (n_ss_in),
        .level_out (ss_level),
        .rise_out  (ss_rise),
        .fall_out  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .async_in  (mosi_in),
        .level_out (mosi_s),
        .rise_out  (mosi_rise),
        .fall_out  (mosi_fall)
    );

    assign unused_sync = ^{sclk_level, ss_level, mosi_rise, mosi_fall};

    assign rx_byte  = {shift_in_q, mosi_s};
    assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 5'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ss_rise) begin
            state_d = IDLE;
        end else if (ss_fall) begin
            state_d = CMD;
        end else if (cmd_done) begin
            state_d = rx_byte[CMD_DIR_BIT] ? WDATA : RDATA;
        end
    end

    // Select edges take priority over any SCLK edge seen in the same cycle.
    always_comb begin
        ss_edge   = ss_rise | ss_fall;
        byte_done = sclk_rise && !ss_edge && (state_q != IDLE) && (bit_cnt_q == 3'd7);
        cmd_done  = byte_done && (state_q == CMD);
        wr_fire   = byte_done && (state_q == WDATA);
        rd_load   = sclk_fall && !ss_edge && load_pending_q && (state_q == RDATA);
    end

`ifdef SPI_RESPONDER_IRQ_EN
    logic       n_int_q, n_int_d;
    logic [7:0] irq_clear;
    assign irq_clear = (wr_fire && (addr_q == ADDR_IRQ)) ? rx_byte : 8'h00;
`endif

    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        shift_in_d     = shift_in_q;
        shift_out_d    = shift_out_q;
        addr_d         = addr_q;
        load_pending_d = load_pending_q;
        miso_d         = miso_q;
        wr_valid_d     = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        rd_data_d      = regs_q[rd_addr_in];
        regs_d         = regs_q;

        if (ss_rise) begin
            bit_cnt_d      = '0;
            miso_d         = 1'b0;
            load_pending_d = 1'b0;
        end else if (ss_fall) begin
            bit_cnt_d      = '0;
            shift_out_d    = status_in;
            miso_d         = status_in[7];
            load_pending_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                shift_in_d     = {shift_in_q[5:0], mosi_s};
                bit_cnt_d      = bit_cnt_q + 3'd1;
                load_pending_d = byte_done;
            end
            // A read byte is fetched on the first fall after the previous byte completes.
            if (sclk_fall) begin
                load_pending_d = 1'b0;
                if (rd_load) begin
                    shift_out_d = regs_q[addr_q];
                    miso_d      = regs_q[addr_q][7];
                end else begin
                    shift_out_d = {shift_out_q[6:0], 1'b0};
                    miso_d      = shift_out_q[6];
                end
            end
            if (cmd_done) begin
                addr_d = rx_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
            end
            if (wr_fire || rd_load) begin
                addr_d = addr_inc;
            end
            if (wr_fire) begin
                wr_valid_d     = 1'b1;
                wr_addr_d      = addr_q;
                wr_data_d      = rx_byte;
                regs_d[addr_q] = rx_byte;
            end
        end

`ifdef SPI_RESPONDER_IRQ_EN
        // IRQ is write-one-to-clear; a same-cycle set beats the clear.
        regs_d[ADDR_IRQ] = (regs_q[ADDR_IRQ] & ~irq_clear) | irq_in;
        n_int_d          = ~|(regs_d[ADDR_IRQ] & regs_d[ADDR_IEN]);
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_cnt_q      <= '0;
            shift_in_q     <= '0;
            shift_out_q    <= '0;
            addr_q         <= '0;
            load_pending_q <= 1'b0;
            miso_q         <= 1'b0;
            wr_valid_q     <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_data_q      <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
`ifdef SPI_RESPONDER_IRQ_EN
            n_int_q        <= 1'b1;
`endif
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            shift_in_q     <= shift_in_d;
            shift_out_q    <= shift_out_d;
            addr_q         <= addr_d;
            load_pending_q <= load_pending_d;
            miso_q         <= miso_d;
            wr_valid_q     <= wr_valid_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_data_q      <= rd_data_d;
            regs_q         <= regs_d;
`ifdef SPI_RESPONDER_IRQ_EN
            n_int_q        <= n_int_d;
`endif
        end
    end

    assign miso_out     = miso_q;
    assign rd_data_out  = rd_data_q;
    assign wr_valid_out = wr_valid_q;
    assign wr_addr_out  = wr_addr_q;
    assign wr_data_out  = wr_data_q;
`ifdef SPI_RESPONDER_IRQ_EN
    assign n_int_out    = n_int_q;
`endif

endmodule
